// File: rtl/reorder_buffer_mc_pkg.sv
// Shared types and sizing for the multi-commit reorder buffer.
// Consumers: reorder_buffer_mc and rob_commit_select.
package reorder_buffer_mc_pkg;

    localparam int ADDR_WIDTH          = 32;
    localparam int DATA_WIDTH          = 32;
    localparam int ROB_PHYS_BITS       = 6;
    localparam int ROB_MC_DEPTH        = 16;
    localparam int ROB_MC_COMMIT_WIDTH = 2;
    localparam int NUM_CDB             = 2;
    localparam int ROB_MC_TAG_BITS     = $clog2(ROB_MC_DEPTH);

    typedef enum logic [1:0] {
        INST_ALU    = 2'd0,
        INST_LOAD   = 2'd1,
        INST_STORE  = 2'd2,
        INST_BRANCH = 2'd3
    } inst_type_e;

    typedef struct packed {
        logic                     valid;
        logic                     ready;
        logic                     jump_reg;
        inst_type_e               inst_type;
        logic [ROB_PHYS_BITS-1:0] reg_dest;
        logic [4:0]               logic_dest;
        logic [ADDR_WIDTH-1:0]    pc;
        logic [DATA_WIDTH-1:0]    value;
        logic [ADDR_WIDTH-1:0]    mem_dest;
    } rob_entry;

    typedef struct packed {
        logic                       valid;
        logic [ROB_MC_TAG_BITS-1:0] tag;
        logic [DATA_WIDTH-1:0]      value;
        logic [ADDR_WIDTH-1:0]      mem_dest;
    } rob_wb_t;

    // Distance from an older pointer to a younger one around the ring.
    function automatic logic [ROB_MC_TAG_BITS-1:0] ring_dist(
        input logic [ROB_MC_TAG_BITS-1:0] from,
        input logic [ROB_MC_TAG_BITS-1:0] to
    );
        return to - from;
    endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Combinational retire scan: walks from head and stops at the first entry
// that is not both valid and ready, producing a thermometer-coded slot mask.
module rob_commit_select
    import reorder_buffer_mc_pkg::*;
#(
    parameter int DEPTH        = ROB_MC_DEPTH,
    parameter int COMMIT_WIDTH = ROB_MC_COMMIT_WIDTH,
    localparam int TAG_BITS    = $clog2(DEPTH)
) (
    input  logic [TAG_BITS-1:0]     head,
    input  logic [DEPTH-1:0]        valid,
    input  logic [DEPTH-1:0]        ready,
    input  logic                    commit_stall,
    output logic [COMMIT_WIDTH-1:0] commit_valid,
    output logic [TAG_BITS:0]       n_commit
);

    always_comb begin
        logic                runOk;
        logic [TAG_BITS-1:0] idx;
        runOk        = !commit_stall;
        idx          = head;
        commit_valid = '0;
        n_commit     = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            idx             = head + TAG_BITS'(i);
            runOk           = runOk & valid[idx] & ready[idx];
            commit_valid[i] = runOk;
            n_commit        = n_commit + (TAG_BITS+1)'(runOk);
        end
    end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Multi-port reorder buffer: in-order alloc, NUM_CDB writebacks, up to
// COMMIT_WIDTH in-order retirements. ROB_PARTIAL_FLUSH_EN enables tag-based squash.
module reorder_buffer_mc #(
    parameter int DEPTH        = reorder_buffer_mc_pkg::ROB_MC_DEPTH,
    parameter int NUM_CDB      = reorder_buffer_mc_pkg::NUM_CDB,
    parameter int COMMIT_WIDTH = reorder_buffer_mc_pkg::ROB_MC_COMMIT_WIDTH,
    parameter int PHYS_BITS    = reorder_buffer_mc_pkg::ROB_PHYS_BITS,
    localparam int TAG_BITS    = $clog2(DEPTH),
    localparam int AW          = reorder_buffer_mc_pkg::ADDR_WIDTH,
    localparam int DW          = reorder_buffer_mc_pkg::DATA_WIDTH
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         alloc_valid,
    output logic                                         alloc_ready,
    input  logic                                         alloc_jump_reg,
    input  logic [1:0]                                   alloc_inst_type,
    input  logic [PHYS_BITS-1:0]                         alloc_reg_dest,
    input  logic [4:0]                                   alloc_logic_dest,
    input  logic [AW-1:0]                                alloc_pc,
    output logic [TAG_BITS-1:0]                          alloc_tag,
    input  logic [NUM_CDB-1:0]                           wb_valid,
    input  logic [NUM_CDB-1:0][TAG_BITS-1:0]             wb_tag,
    input  logic [NUM_CDB-1:0][DW-1:0]                   wb_value,
    input  logic [NUM_CDB-1:0][AW-1:0]                   wb_mem_dest,
    input  logic                                         commit_stall,
    output logic [COMMIT_WIDTH-1:0]                      commit_valid,
    output reorder_buffer_mc_pkg::rob_entry [COMMIT_WIDTH-1:0] commit_entry,
    input  logic                                         flush_valid,
    input  logic [TAG_BITS-1:0]                          flush_tag,
    output logic [TAG_BITS:0]                            count,
    output logic                                         empty,
    output logic                                         full
);

    import reorder_buffer_mc_pkg::*;

    logic [TAG_BITS-1:0] head_q, head_d;
    logic [TAG_BITS-1:0] tail_q, tail_d;
    logic [TAG_BITS:0]   count_q, count_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DEPTH-1:0]    ready_q, ready_d;
    rob_entry            payload_q [DEPTH];

    rob_wb_t             wb [NUM_CDB];
    logic                allocFire;
    logic                stallEff;
    logic [TAG_BITS:0]   nCommit;
    logic                dupWb;

    always_comb begin
        for (int c = 0; c < NUM_CDB; c++) begin
            wb[c].valid    = wb_valid[c];
            wb[c].tag      = wb_tag[c];
            wb[c].value    = wb_value[c];
            wb[c].mem_dest = wb_mem_dest[c];
        end
    end

    assign full        = (count_q == (TAG_BITS+1)'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign alloc_tag   = tail_q;
    assign alloc_ready = !full && !flush_valid;
    assign allocFire   = alloc_valid && alloc_ready;

`ifdef ROB_PARTIAL_FLUSH_EN
    logic [TAG_BITS-1:0] flushDist;
    assign flushDist = ring_dist(head_q, flush_tag);
    assign stallEff  = commit_stall;
`else
    // A full flush discards everything, so nothing may retire alongside it.
    logic flushTagUnused;
    assign flushTagUnused = ^flush_tag;
    assign stallEff       = commit_stall | flush_valid;
`endif

    rob_commit_select #(
        .DEPTH        (DEPTH),
        .COMMIT_WIDTH (COMMIT_WIDTH)
    ) u_commit_select (
        .head         (head_q),
        .valid        (valid_q),
        .ready        (ready_q),
        .commit_stall (stallEff),
        .commit_valid (commit_valid),
        .n_commit     (nCommit)
    );

    // Next-state: writeback, retire, allocate, then flush has the final say.
    always_comb begin
        logic [TAG_BITS-1:0] idx;
        logic [TAG_BITS-1:0] age;
        idx     = head_q;
        age     = '0;
        valid_d = valid_q;
        ready_d = ready_q;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (wb[c].valid && valid_q[wb[c].tag]) begin
                ready_d[wb[c].tag] = 1'b1;
            end
        end
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            idx = head_q + TAG_BITS'(i);
            if (commit_valid[i]) begin
                valid_d[idx] = 1'b0;
                ready_d[idx] = 1'b0;
            end
        end
        if (allocFire) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = 1'b0;
        end
        head_d  = head_q + TAG_BITS'(nCommit);
        tail_d  = tail_q + TAG_BITS'(allocFire);
        count_d = count_q + (TAG_BITS+1)'(allocFire) - nCommit;
        if (flush_valid) begin
`ifdef ROB_PARTIAL_FLUSH_EN
            for (int j = 0; j < DEPTH; j++) begin
                age = ring_dist(head_q, TAG_BITS'(j));
                if (age > flushDist) begin
                    valid_d[j] = 1'b0;
                    ready_d[j] = 1'b0;
                end
            end
            tail_d  = flush_tag + 1'b1;
            count_d = {1'b0, flushDist} + 1'b1 - nCommit;
`else
            age     = '0;
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Payload needs no reset: valid/ready qualify every use of it.
    always_ff @(posedge clk) begin
        if (allocFire) begin
            payload_q[tail_q] <= '{
                valid:      1'b1,
                ready:      1'b0,
                jump_reg:   alloc_jump_reg,
                inst_type:  inst_type_e'(alloc_inst_type),
                reg_dest:   alloc_reg_dest,
                logic_dest: alloc_logic_dest,
                pc:         alloc_pc,
                value:      '0,
                mem_dest:   '0
            };
        end
        for (int c = 0; c < NUM_CDB; c++) begin
            if (wb[c].valid && valid_q[wb[c].tag]) begin
                payload_q[wb[c].tag].value    <= wb[c].value;
                payload_q[wb[c].tag].mem_dest <= wb[c].mem_dest;
            end
        end
    end

    always_comb begin
        logic [TAG_BITS-1:0] idx;
        idx = head_q;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            idx                   = head_q + TAG_BITS'(i);
            commit_entry[i]       = payload_q[idx];
            commit_entry[i].valid = valid_q[idx];
            commit_entry[i].ready = ready_q[idx];
        end
    end

    always_comb begin
        dupWb = 1'b0;
        for (int a = 0; a < NUM_CDB; a++) begin
            for (int b = a + 1; b < NUM_CDB; b++) begin
                if (wb[a].valid && wb[b].valid && (wb[a].tag == wb[b].tag)) begin
                    dupWb = 1'b1;
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !dupWb);

endmodule
